// File: rtl/psum_feeder_pkg.sv
// Shared definitions for the partial-sum feeder.
//
// Holds the feeder FSM state encoding, the SETTLE length, the counter widths
// and the default lane geometry used by psum_feeder and its parent.
package psum_feeder_pkg;

  // Default lane geometry: number of output columns / SFU lanes and psum width.
  localparam int unsigned DefaultCol    = 8;
  localparam int unsigned DefaultPsumBw = 16;

  // Cycles spent after the last sfu_valid so the SFU has accumulated it.
  localparam int unsigned SettleLen = 2;

  // Counter / configuration widths. kij_cnt must reach 15 and grp_cnt must
  // reach 65535 without wrapping.
  localparam int unsigned KijW = 4;
  localparam int unsigned GrpW = 16;

  // SETTLE counter width, never zero.
  localparam int unsigned SettleCntW = (SettleLen > 1) ? $clog2(SettleLen) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StSettle,
    StFin
  } feeder_state_e;

endpackage

// File: rtl/psum_feeder.sv
// Partial-sum feeder.
//
// Pops psum vectors from a show-ahead FIFO and streams them, unmodified, to a
// row of SFU lane accumulators. Vectors are grouped: each group clears the
// SFU, feeds kij_num vectors, waits for the SFU to absorb the last one, then
// flags acc_done. After num_groups groups the block pulses done.
//
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   start       - one-cycle pulse; latches kij_num/num_groups when idle
//   kij_num     - vectors per group (0 behaves as 1)
//   num_groups  - number of groups to run (0 is legal: straight to done)
//   fifo_empty  - source FIFO empty flag; fifo_dout valid whenever low
//   fifo_dout   - head-of-FIFO psum vector, lane i at [i*psum_bw +: psum_bw]
//   fifo_rd     - combinational pop strobe, never high while fifo_empty
//   sfu_clr     - registered pulse clearing all SFU lane accumulators
//   sfu_valid   - registered in_valid for all SFU lanes
//   sfu_data    - registered psum vector accompanying sfu_valid
//   acc_done    - registered pulse: SFU outputs hold a complete group sum
//   busy        - high whenever the FSM is not idle
//   done        - registered pulse when all groups have completed
module psum_feeder
  import psum_feeder_pkg::*;
#(
  parameter int unsigned col     = DefaultCol,
  parameter int unsigned psum_bw = DefaultPsumBw
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KijW-1:0]        kij_num,
  input  logic [GrpW-1:0]        num_groups,
  input  logic                   fifo_empty,
  input  logic [col*psum_bw-1:0] fifo_dout,
  output logic                   fifo_rd,
  output logic                   sfu_clr,
  output logic                   sfu_valid,
  output logic [col*psum_bw-1:0] sfu_data,
  output logic                   acc_done,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned DataW = col * psum_bw;

  feeder_state_e         state_q, state_d;
  logic [KijW-1:0]       kij_num_q, kij_num_d;
  logic [GrpW-1:0]       num_groups_q, num_groups_d;
  logic [KijW-1:0]       kij_cnt_q, kij_cnt_d;
  logic [GrpW-1:0]       grp_cnt_q, grp_cnt_d;
  logic [SettleCntW-1:0] settle_cnt_q, settle_cnt_d;

  logic             sfu_clr_q, sfu_clr_d;
  logic             sfu_valid_q, sfu_valid_d;
  logic [DataW-1:0] sfu_data_q, sfu_data_d;
  logic             acc_done_q, acc_done_d;
  logic             done_q, done_d;

  logic pop;
  logic last_pop;
  logic settle_last;
  logic more_groups;

  // kij_num_q is stored already clamped to >= 1, so the subtraction is safe.
  assign pop         = (state_q == StFeed) && !fifo_empty && (kij_cnt_q < kij_num_q);
  assign last_pop    = pop && (kij_cnt_q == (kij_num_q - KijW'(1)));
  assign settle_last = (settle_cnt_q == SettleCntW'(SettleLen - 1));
  // Widened by one bit so the compare is exact at num_groups = 65535.
  assign more_groups = ({1'b0, grp_cnt_q} + (GrpW + 1)'(1)) < {1'b0, num_groups_q};

  always_comb begin
    state_d      = state_q;
    kij_num_d    = kij_num_q;
    num_groups_d = num_groups_q;
    kij_cnt_d    = kij_cnt_q;
    grp_cnt_d    = grp_cnt_q;
    settle_cnt_d = settle_cnt_q;
    sfu_clr_d    = 1'b0;
    sfu_valid_d  = 1'b0;
    sfu_data_d   = sfu_data_q;
    acc_done_d   = 1'b0;
    done_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          kij_num_d    = (kij_num == '0) ? KijW'(1) : kij_num;
          num_groups_d = num_groups;
          kij_cnt_d    = '0;
          grp_cnt_d    = '0;
          state_d      = (num_groups == '0) ? StFin : StClear;
        end
      end
      StClear: begin
        sfu_clr_d = 1'b1;
        state_d   = StFeed;
      end
      StFeed: begin
        if (pop) begin
          sfu_valid_d = 1'b1;
          sfu_data_d  = fifo_dout;
          kij_cnt_d   = kij_cnt_q + KijW'(1);
          if (last_pop) begin
            settle_cnt_d = '0;
            state_d      = StSettle;
          end
        end
      end
      StSettle: begin
        if (settle_last) begin
          acc_done_d = 1'b1;
          grp_cnt_d  = grp_cnt_q + GrpW'(1);
          kij_cnt_d  = '0;
          state_d    = more_groups ? StClear : StFin;
        end else begin
          settle_cnt_d = settle_cnt_q + SettleCntW'(1);
        end
      end
      StFin: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      kij_num_q    <= '0;
      num_groups_q <= '0;
      kij_cnt_q    <= '0;
      grp_cnt_q    <= '0;
      settle_cnt_q <= '0;
      sfu_clr_q    <= 1'b0;
      sfu_valid_q  <= 1'b0;
      sfu_data_q   <= '0;
      acc_done_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      kij_num_q    <= kij_num_d;
      num_groups_q <= num_groups_d;
      kij_cnt_q    <= kij_cnt_d;
      grp_cnt_q    <= grp_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      sfu_clr_q    <= sfu_clr_d;
      sfu_valid_q  <= sfu_valid_d;
      sfu_data_q   <= sfu_data_d;
      acc_done_q   <= acc_done_d;
      done_q       <= done_d;
    end
  end

  assign fifo_rd   = pop;
  assign sfu_clr   = sfu_clr_q;
  assign sfu_valid = sfu_valid_q;
  assign sfu_data  = sfu_data_q;
  assign acc_done  = acc_done_q;
  assign done      = done_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_psum_feeder.sv
// Self-checking bench for psum_feeder: FIFO model, lane-0 SFU accumulator
// model and a queue of expected group sums.
module tb_psum_feeder;
  import psum_feeder_pkg::*;

  localparam int unsigned Col = 8;
  localparam int unsigned Bw  = 16;
  localparam int unsigned W   = Col * Bw;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   kij_num;
  logic [15:0]  num_groups;
  logic         fifo_empty;
  logic [W-1:0] fifo_dout;
  logic         fifo_rd;
  logic         sfu_clr;
  logic         sfu_valid;
  logic [W-1:0] sfu_data;
  logic         acc_done;
  logic         busy;
  logic         done;

  psum_feeder #(
    .col     (Col),
    .psum_bw (Bw)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .kij_num    (kij_num),
    .num_groups (num_groups),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd    (fifo_rd),
    .sfu_clr    (sfu_clr),
    .sfu_valid  (sfu_valid),
    .sfu_data   (sfu_data),
    .acc_done   (acc_done),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] fifo_q[$];
  logic [63:0]  exp_sum_q[$];
  int           gap_left, gap_at, gap_len, pops_case;
  logic         mon_en;
  logic         pend_valid;
  logic [W-1:0] pend_data;
  logic [63:0]  acc0;
  int           acc_cnt, pop_cnt, clr_cnt, done_cnt, cyc, done_cyc;
  logic         s_busy, s_valid, s_clr, s_acc_done, s_done, s_rd;
  logic [W-1:0] s_data;

  typedef struct {
    int kij;
    int groups;
    int gap_at;
    int gap_len;
    int mode;       // 0: lane0 = 1,2,3..  1: all lanes 0x7FFF  2: random
    int restart_at; // cycle after start to pulse a second start, 0 = none
    int exp_pops;
    int exp_acc;
  } case_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic upd_fifo();
    fifo_empty = (fifo_q.size() == 0) || (gap_left > 0);
    fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic clear_counts();
    acc_cnt   = 0;
    pop_cnt   = 0;
    clr_cnt   = 0;
    done_cnt  = 0;
    done_cyc  = 0;
    pops_case = 0;
    gap_left  = 0;
    gap_at    = 0;
    gap_len   = 0;
  endtask

  // One clock cycle: observe and check at the falling edge, then apply the
  // FIFO pop just after the rising edge.
  task automatic step();
    logic do_pop;
    @(negedge clk);
    cyc++;
    s_busy     = busy;
    s_valid    = sfu_valid;
    s_clr      = sfu_clr;
    s_data     = sfu_data;
    s_acc_done = acc_done;
    s_done     = done;
    s_rd       = fifo_rd;
    do_pop     = 1'b0;
    if (mon_en) begin
      if (acc_done) begin
        acc_cnt++;
        if (exp_sum_q.size() == 0) chk("extra_acc_done", acc_done, 1'b0);
        else chk("group_sum", acc0, exp_sum_q.pop_front());
      end
      chk("clr_valid_excl", sfu_clr & sfu_valid, 1'b0);
      chk("rd_when_empty", fifo_rd & fifo_empty, 1'b0);
      chk("sfu_valid", sfu_valid, pend_valid);
      if (pend_valid) chk("sfu_data", sfu_data, pend_data);
      if (sfu_clr) begin
        acc0 = '0;
        clr_cnt++;
      end
      if (sfu_valid) acc0 = acc0 + 64'(sfu_data[Bw-1:0]);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      pend_valid = fifo_rd;
      if (fifo_rd) pend_data = fifo_dout;
      do_pop = fifo_rd;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      pend_valid = 1'b0;
      fifo_q.delete();
      exp_sum_q.delete();
      gap_left = 0;
    end else begin
      if (gap_left > 0) gap_left--;
      if (do_pop && fifo_q.size() != 0) begin
        void'(fifo_q.pop_front());
        pops_case++;
        pop_cnt++;
        if (gap_len > 0 && pops_case == gap_at) gap_left = gap_len;
      end
    end
    upd_fifo();
  endtask

  // Preload the FIFO for kij x groups and push the expected lane-0 group sums.
  task automatic load(input int kij, input int groups, input int mode);
    int           keff;
    int           v;
    logic [63:0]  sum;
    logic [W-1:0] vec;
    logic [Bw-1:0] l0;
    keff = (kij == 0) ? 1 : kij;
    v    = 1;
    fifo_q.delete();
    exp_sum_q.delete();
    for (int g = 0; g < groups; g++) begin
      sum = '0;
      for (int k = 0; k < keff; k++) begin
        for (int i = 0; i < Col; i++) vec[i*Bw +: Bw] = Bw'($urandom);
        if (mode == 0) l0 = Bw'(v);
        else if (mode == 1) l0 = 16'h7fff;
        else l0 = Bw'($urandom_range(0, 4095));
        if (mode == 1) for (int i = 0; i < Col; i++) vec[i*Bw +: Bw] = 16'h7fff;
        vec[Bw-1:0] = l0;
        fifo_q.push_back(vec);
        sum = sum + 64'(l0);
        v++;
      end
      exp_sum_q.push_back(sum);
    end
    upd_fifo();
  endtask

  task automatic run_case(input case_t c);
    int n;
    clear_counts();
    gap_at  = c.gap_at;
    gap_len = c.gap_len;
    load(c.kij, c.groups, c.mode);
    kij_num    = 4'(c.kij);
    num_groups = 16'(c.groups);
    start      = 1'b1;
    step();
    start      = 1'b0;
    // Scramble config after start: the block must use its latched copy.
    kij_num    = 4'd7;
    num_groups = 16'd9;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      if (c.restart_at != 0 && n == c.restart_at) start = 1'b1;
      step();
      start = 1'b0;
      n++;
    end
    step();
    step();
    chk("done_count", done_cnt, 1);
    chk("pop_count", pop_cnt, c.exp_pops);
    chk("acc_done_count", acc_cnt, c.exp_acc);
    chk("clr_count", clr_cnt, c.exp_acc);
    chk("sums_left", exp_sum_q.size(), 0);
    chk("busy_after", s_busy, 1'b0);
  endtask

  case_t cases[7];

  initial begin
    int n;
    int start_cyc;
    cases[0] = '{kij: 3,  groups: 2, gap_at: 0, gap_len: 0, mode: 0, restart_at: 0,
                 exp_pops: 6,  exp_acc: 2};
    cases[1] = '{kij: 9,  groups: 1, gap_at: 0, gap_len: 0, mode: 0, restart_at: 0,
                 exp_pops: 9,  exp_acc: 1};
    cases[2] = '{kij: 9,  groups: 1, gap_at: 4, gap_len: 5, mode: 0, restart_at: 0,
                 exp_pops: 9,  exp_acc: 1};
    cases[3] = '{kij: 0,  groups: 1, gap_at: 0, gap_len: 0, mode: 1, restart_at: 0,
                 exp_pops: 1,  exp_acc: 1};
    cases[4] = '{kij: 15, groups: 3, gap_at: 7, gap_len: 3, mode: 2, restart_at: 0,
                 exp_pops: 45, exp_acc: 3};
    cases[5] = '{kij: 1,  groups: 4, gap_at: 0, gap_len: 0, mode: 2, restart_at: 0,
                 exp_pops: 4,  exp_acc: 4};
    cases[6] = '{kij: 2,  groups: 2, gap_at: 0, gap_len: 0, mode: 0, restart_at: 3,
                 exp_pops: 4,  exp_acc: 2};

    rst        = 1'b1;
    start      = 1'b0;
    kij_num    = '0;
    num_groups = '0;
    mon_en     = 1'b0;
    pend_valid = 1'b0;
    pend_data  = '0;
    acc0       = '0;
    cyc        = 0;
    clear_counts();
    fifo_q.delete();
    upd_fifo();
    step();
    step();
    rst    = 1'b0;
    mon_en = 1'b1;
    step();
    chk("rst_busy", s_busy, 1'b0);
    chk("rst_valid", s_valid, 1'b0);
    chk("rst_clr", s_clr, 1'b0);
    chk("rst_data", s_data, '0);
    chk("rst_acc_done", s_acc_done, 1'b0);
    chk("rst_done", s_done, 1'b0);
    chk("rst_fifo_rd", s_rd, 1'b0);

    for (int i = 0; i < 7; i++) run_case(cases[i]);

    // num_groups = 0: no pops, no clear, done two cycles after start.
    clear_counts();
    fifo_q.delete();
    exp_sum_q.delete();
    upd_fifo();
    kij_num    = 4'd3;
    num_groups = 16'd0;
    start      = 1'b1;
    step();
    start_cyc  = cyc;
    start      = 1'b0;
    step();
    chk("zero_grp_busy", s_busy, 1'b1);
    for (int i = 0; i < 4; i++) step();
    chk("zero_grp_done_count", done_cnt, 1);
    chk("zero_grp_done_lat", done_cyc - start_cyc, 2);
    chk("zero_grp_pops", pop_cnt, 0);
    chk("zero_grp_clr", clr_cnt, 0);

    // Reset after two of nine pops: everything quiet next cycle, no acc_done.
    clear_counts();
    load(9, 1, 0);
    kij_num    = 4'd9;
    num_groups = 16'd1;
    start      = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (pop_cnt < 2 && n < 100) begin
      step();
      n++;
    end
    chk("pre_rst_pops", pop_cnt, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("mid_rst_busy", s_busy, 1'b0);
    chk("mid_rst_valid", s_valid, 1'b0);
    chk("mid_rst_clr", s_clr, 1'b0);
    chk("mid_rst_data", s_data, '0);
    chk("mid_rst_acc_done", s_acc_done, 1'b0);
    chk("mid_rst_done", s_done, 1'b0);
    chk("mid_rst_fifo_rd", s_rd, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk("mid_rst_no_acc", acc_cnt, 0);
    run_case(cases[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psum_feeder.md
PSUM_FEEDER -- requirements
Module: psum_feeder

Interface
REQ-001 Parameter col, default 8, number of output columns and SFU lanes.
REQ-002 Parameter psum_bw, default 16, partial-sum width per lane.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse; latches kij_num and num_groups when idle.
REQ-006 kij_num  input  4  vectors accumulated per group; 0 treated as 1.
REQ-007 num_groups  input  16  groups (output positions) to process; 0 legal.
REQ-008 fifo_empty  input  1  source FIFO empty; show-ahead, so fifo_dout is valid whenever low.
REQ-009 fifo_dout  input  col*psum_bw  head-of-FIFO psum vector; lane i at bits [i*psum_bw +: psum_bw].
REQ-010 fifo_rd  output  1  pop strobe, combinational, asserted only when fifo_empty is low.
REQ-011 sfu_clr  output  1  registered one-cycle pulse that clears every SFU lane accumulator.
REQ-012 sfu_valid  output  1  registered; drives in_valid of every SFU lane.
REQ-013 sfu_data  output  col*psum_bw  registered psum vector that accompanies sfu_valid.
REQ-014 acc_done  output  1  one-cycle pulse; SFU outputs hold a complete group sum.
REQ-015 busy  output  1  high in every state other than IDLE.
REQ-016 done  output  1  one-cycle pulse when all groups are complete.

Function
REQ-017 FSM states SHALL be IDLE, CLEAR, FEED, SETTLE, FIN.
REQ-018 IDLE: on start, the block latches its configuration and resets grp_cnt and kij_cnt to 0. It goes to FIN if num_groups==0, otherwise to CLEAR.
REQ-019 CLEAR lasts exactly 1 cycle, and sfu_clr is high on the following cycle. The next state is FEED.
REQ-020 FEED: fifo_rd = !fifo_empty and kij_cnt < kij_num. Each pop increments kij_cnt.
REQ-021 The cycle after each pop, sfu_valid SHALL be 1 and sfu_data SHALL equal the popped fifo_dout. Otherwise sfu_valid is 0 and sfu_data holds its last value.
REQ-022 If fifo_empty is high in FEED, the block stalls with no pop and no sfu_valid. There is no timeout.
REQ-023 After the pop that makes kij_cnt equal kij_num, the block goes to SETTLE.
REQ-024 SETTLE lasts exactly 2 cycles, so the last sfu_valid has been accumulated by the SFU.
REQ-025 acc_done SHALL pulse in the cycle immediately after SETTLE exits. At that point grp_cnt increments and kij_cnt clears.
REQ-026 After SETTLE, the block goes to CLEAR if grp_cnt+1 < num_groups, otherwise to FIN.
REQ-027 FIN lasts 1 cycle, done pulses the next cycle, and the block returns to IDLE.
REQ-028 start SHALL be ignored while busy.
REQ-029 sfu_clr and sfu_valid SHALL never be high in the same cycle.
REQ-030 The block SHALL NOT modify data; no arithmetic is performed on psums.
REQ-031 Counters SHALL be sized to reach num_groups=65535 and kij_num=15 without wrap.

Reset
REQ-032 rst SHALL force IDLE and clear grp_cnt, kij_cnt and latched configuration.
REQ-033 rst SHALL clear sfu_valid, sfu_clr, sfu_data, acc_done and done to 0, and fifo_rd is 0.
REQ-034 rst SHALL take priority over all other inputs, including mid-group. Any partial group is abandoned with no acc_done.
REQ-035 After reset, the SFU clear is the owner's responsibility; the first group still issues sfu_clr.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding, the SETTLE length constant (2) and the default col and psum_bw.
REQ-037 The block is one module with no sub-modules; the SFU lanes are instantiated by the parent.

Verification
REQ-038 kij_num=3, num_groups=2, FIFO preloaded with 6 vectors, lane0 values 1..6. Required: lane0 SFU result is 6 at the first acc_done and 15 at the second; then done.
REQ-039 FIFO empty for 5 cycles mid-group (kij_num=9). Required: no fifo_rd and no sfu_valid during the gap; the final sum is unchanged versus the no-gap run.
REQ-040 num_groups=0 with start. Required: no fifo_rd, no sfu_clr, and done pulses exactly 2 cycles after start.
REQ-041 Second start asserted while busy. Required: ignored, with exactly the originally configured number of acc_done pulses.
REQ-042 rst asserted after 2 of 9 pops. Required: all outputs 0 and busy 0 next cycle; a fresh start runs correctly.
REQ-043 kij_num=0, num_groups=1, lane values 0x7FFF. Required: exactly one pop and acc_done with SFU value 0x7FFF.
